// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and helpers for the dmem port arbiter: state encoding, width helper,
// and packed-field slice macros for the flattened per-requester buses.
package dmem_port_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for values <= 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

endpackage

`ifndef DPA_SLICE_MACROS
`define DPA_SLICE_MACROS
`define DPA_ADDR_SLICE(k) (32'(k) * ADDR_W) +: ADDR_W
`define DPA_DATA_SLICE(k) (32'(k) * DATA_W) +: DATA_W
`endif

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and dmem-side signal bundle of the dmem port arbiter.
interface dmem_port_arbiter_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
);

  logic [N-1:0]        i_REQ;
  logic [N-1:0]        i_WE;
  logic [N-1:0]        i_LOCK;
  logic [N*ADDR_W-1:0] i_ADDR;
  logic [N*DATA_W-1:0] i_WDATA;
  logic [N-1:0]        o_GNT;
  logic [N-1:0]        o_RVALID;
  logic [DATA_W-1:0]   o_RDATA;
  logic                o_LOCK_ERR;

  logic                o_MEM_ENa;
  logic                o_MEM_WEa;
  logic [ADDR_W-1:0]   o_MEM_ADDRa;
  logic [DATA_W-1:0]   o_MEM_WDATAa;
  logic                o_MEM_ENc;
  logic [ADDR_W-1:0]   o_MEM_ADDRc;
  logic [DATA_W-1:0]   i_MEM_RDATAc;

  modport master (
    input  i_REQ, i_WE, i_LOCK, i_ADDR, i_WDATA, i_MEM_RDATAc,
    output o_GNT, o_RVALID, o_RDATA, o_LOCK_ERR,
    output o_MEM_ENa, o_MEM_WEa, o_MEM_ADDRa, o_MEM_WDATAa,
    output o_MEM_ENc, o_MEM_ADDRc
  );

  modport slave (
    output i_REQ, i_WE, i_LOCK, i_ADDR, i_WDATA, i_MEM_RDATAc,
    input  o_GNT, o_RVALID, o_RDATA, o_LOCK_ERR,
    input  o_MEM_ENa, o_MEM_WEa, o_MEM_ADDRa, o_MEM_WDATAa,
    input  o_MEM_ENc, o_MEM_ADDRc
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_priority_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    logic             found;
    int unsigned      pos;
    logic [IDX_W-1:0] cand;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= N) pos = pos - N;
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing dmem write port a and read port c among N requesters,
// with locked read-modify-write sequences bounded by a forced-release timeout.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 64
) (
  input logic                 i_CLK,
  input logic                 i_RSTn,
  dmem_port_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam int unsigned CNT_W = (clog2(LOCK_MAX) < 1) ? 1 : clog2(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] lock_cnt;
  logic [N-1:0]     rvalid_q;
  logic             lock_err_q;

  logic [N-1:0]     pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             xfer;
  logic             xfer_we;
  logic             xfer_lock;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (32'(idx) == N - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  rr_priority_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (bus.i_REQ),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // Grant: round-robin pick in IDLE, owner only while LOCKED, nothing during reset
  always_comb begin
    gnt     = '0;
    gnt_idx = pick_idx;
    if (state == ST_LOCKED) begin
      gnt_idx    = owner;
      gnt[owner] = bus.i_REQ[owner];
    end else begin
      gnt = pick_gnt;
    end
    if (!i_RSTn) gnt = '0;
  end

  assign xfer      = |gnt;
  assign xfer_we   = bus.i_WE[gnt_idx];
  assign xfer_lock = bus.i_LOCK[gnt_idx];

  // One transaction per cycle, so the two port enables are mutually exclusive
  assign bus.o_GNT        = gnt;
  assign bus.o_MEM_ENa    = xfer & xfer_we;
  assign bus.o_MEM_WEa    = xfer & xfer_we;
  assign bus.o_MEM_ADDRa  = bus.i_ADDR[`DPA_ADDR_SLICE(gnt_idx)];
  assign bus.o_MEM_WDATAa = bus.i_WDATA[`DPA_DATA_SLICE(gnt_idx)];
  assign bus.o_MEM_ENc    = xfer & ~xfer_we;
  assign bus.o_MEM_ADDRc  = bus.i_ADDR[`DPA_ADDR_SLICE(gnt_idx)];
  assign bus.o_RDATA      = bus.i_MEM_RDATAc;
  assign bus.o_RVALID     = rvalid_q;
  assign bus.o_LOCK_ERR   = lock_err_q;

  // Arbitration state, rr pointer, lock ownership and timeout counter
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      lock_cnt   <= '0;
      rvalid_q   <= '0;
      lock_err_q <= 1'b0;
    end else begin
      rvalid_q   <= (xfer && !xfer_we) ? gnt : '0;
      lock_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            ptr <= next_idx(gnt_idx);
            if (xfer_lock) begin
              state    <= ST_LOCKED;
              owner    <= gnt_idx;
              lock_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (xfer && !xfer_lock) begin
            state    <= ST_IDLE;
            ptr      <= next_idx(owner);
            lock_cnt <= '0;
          end else if (lock_cnt == CNT_LAST) begin
            // Timeout wins over a lock refresh; the owner's transfer still went out
            state      <= ST_IDLE;
            ptr        <= next_idx(owner);
            lock_cnt   <= '0;
            lock_err_q <= 1'b1;
          end else if (xfer) begin
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration and memory model.
module tb_dmem_port_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LOCK_MAX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(
    .N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Dual-port BRAM stand-in: write-first across edges, one-cycle registered read
  logic              pre_we   = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  bit                mem_vld [0:(1<<ADDR_W)-1];

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr]     <= pre_data;
      mem_vld[pre_addr] <= 1'b1;
    end
    if (bus.o_MEM_ENa && bus.o_MEM_WEa) begin
      mem[bus.o_MEM_ADDRa]     <= bus.o_MEM_WDATAa;
      mem_vld[bus.o_MEM_ADDRa] <= 1'b1;
    end
    if (bus.o_MEM_ENc)
      bus.i_MEM_RDATAc <= mem_vld[bus.o_MEM_ADDRc] ? mem[bus.o_MEM_ADDRc]
                                                   : init_word(int'(bus.o_MEM_ADDRc));
  end

  // Reference model state
  bit                m_locked;
  int                m_owner;
  int                m_ptr;
  int                m_age;
  logic [N-1:0]      m_rv;
  logic [DATA_W-1:0] m_rv_data;
  bit                m_err;
  logic [DATA_W-1:0] mmem [int];

  task automatic clear_inputs();
    bus.i_REQ   = '0;
    bus.i_WE    = '0;
    bus.i_LOCK  = '0;
    bus.i_ADDR  = '0;
    bus.i_WDATA = '0;
  endtask

  task automatic set_req(input int k, input bit we, input bit lk,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.i_REQ[k]  = 1'b1;
    bus.i_WE[k]   = we;
    bus.i_LOCK[k] = lk;
    bus.i_ADDR[k*ADDR_W +: ADDR_W]  = a;
    bus.i_WDATA[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Expected winner: nearest requester at or after the pointer, or only the lock owner
  function automatic int model_winner();
    int best, bestd, d;
    if (m_locked) return bus.i_REQ[m_owner] ? m_owner : -1;
    best = -1; bestd = N;
    for (int k = 0; k < N; k++) begin
      d = (k - m_ptr + N) % N;
      if (bus.i_REQ[k] && d < bestd) begin best = k; bestd = d; end
    end
    return best;
  endfunction

  task automatic model_step(input int w);
    bit nerr;
    int a;
    nerr = 0;
    m_rv = '0;
    if (w >= 0) begin
      a = int'(bus.i_ADDR[w*ADDR_W +: ADDR_W]);
      if (bus.i_WE[w]) mmem[a] = bus.i_WDATA[w*DATA_W +: DATA_W];
      else begin
        m_rv[w]   = 1'b1;
        m_rv_data = mmem.exists(a) ? mmem[a] : init_word(a);
      end
    end
    if (!m_locked) begin
      if (w >= 0) begin
        m_ptr = (w + 1) % N;
        if (bus.i_LOCK[w]) begin m_locked = 1; m_owner = w; m_age = 0; end
      end
    end else if (w >= 0 && !bus.i_LOCK[w]) begin
      m_locked = 0; m_ptr = (m_owner + 1) % N;
    end else if (m_age == LOCK_MAX - 1) begin
      m_locked = 0; m_ptr = (m_owner + 1) % N; nerr = 1;
    end else if (w >= 0) m_age = 0;
    else m_age = m_age + 1;
    m_err = nerr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b0, ADDR_W'(k), '0);
    @(negedge clk); #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt got=%b exp=0000", bus.o_GNT); end
    n_checks++;
    if ({bus.o_MEM_ENa, bus.o_MEM_WEa, bus.o_MEM_ENc} !== 3'b000) begin
      n_errors++; $display("FAIL reset_en got=%b exp=000", {bus.o_MEM_ENa, bus.o_MEM_WEa, bus.o_MEM_ENc});
    end
    n_checks++;
    if ({bus.o_RVALID, bus.o_LOCK_ERR} !== 5'b00000) begin
      n_errors++; $display("FAIL reset_rv_err got=%b exp=00000", {bus.o_RVALID, bus.o_LOCK_ERR});
    end
    rst_n = 1'b1; #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0001) begin n_errors++; $display("FAIL reset_first_gnt got=%b exp=0001", bus.o_GNT); end
    @(negedge clk); #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0010 || bus.o_RVALID !== 4'b0001) begin
      n_errors++; $display("FAIL reset_second got gnt=%b rv=%b exp gnt=0010 rv=0001", bus.o_GNT, bus.o_RVALID);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    preload(15'h0010, 32'hDEAD_BEEF);
    set_req(1, 1'b0, 1'b0, 15'h0010, '0);
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0010 || bus.o_MEM_ENc !== 1'b1 || bus.o_MEM_ENa !== 1'b0 || bus.o_MEM_ADDRc !== 15'h0010) begin
      n_errors++; $display("FAIL single_read_issue got gnt=%b enc=%b ena=%b addr=%h exp gnt=0010 enc=1 ena=0 addr=0010",
                           bus.o_GNT, bus.o_MEM_ENc, bus.o_MEM_ENa, bus.o_MEM_ADDRc);
    end
    @(negedge clk); clear_inputs(); #1;
    n_checks++;
    if (bus.o_RVALID !== 4'b0010 || bus.o_RDATA !== 32'hDEAD_BEEF || bus.o_GNT !== 4'b0000) begin
      n_errors++; $display("FAIL single_read_resp got rv=%b data=%h gnt=%b exp rv=0010 data=deadbeef gnt=0000",
                           bus.o_RVALID, bus.o_RDATA, bus.o_GNT);
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus.o_RVALID !== 4'b0000) begin n_errors++; $display("FAIL single_read_rv_drop got=%b exp=0000", bus.o_RVALID); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_rv;
    do_reset();
    @(negedge clk);
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b0, ADDR_W'(32'h200 + k), '0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_g = '0; exp_g[c % N] = 1'b1;
      n_checks++;
      if (bus.o_GNT !== exp_g) begin n_errors++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, bus.o_GNT, exp_g); end
      if (c > 0) begin
        exp_rv = '0; exp_rv[(c - 1) % N] = 1'b1;
        n_checks++;
        if (bus.o_RVALID !== exp_rv || bus.o_RDATA !== init_word(32'h200 + (c - 1) % N)) begin
          n_errors++; $display("FAIL rr_resp cycle=%0d got rv=%b data=%h exp rv=%b data=%h", c, bus.o_RVALID,
                               bus.o_RDATA, exp_rv, init_word(32'h200 + (c - 1) % N));
        end
      end
    end
  endtask

  task automatic test_write_read();
    do_reset();
    @(negedge clk);
    set_req(2, 1'b1, 1'b0, 15'h0100, 32'h1234_5678);
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0100 || {bus.o_MEM_ENa, bus.o_MEM_WEa, bus.o_MEM_ENc} !== 3'b110 ||
        bus.o_MEM_ADDRa !== 15'h0100 || bus.o_MEM_WDATAa !== 32'h1234_5678) begin
      n_errors++; $display("FAIL wr_issue got gnt=%b en=%b addr=%h data=%h exp gnt=0100 en=110 addr=0100 data=12345678",
                           bus.o_GNT, {bus.o_MEM_ENa, bus.o_MEM_WEa, bus.o_MEM_ENc}, bus.o_MEM_ADDRa, bus.o_MEM_WDATAa);
    end
    @(negedge clk);
    set_req(2, 1'b0, 1'b0, 15'h0100, '0);
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0100 || {bus.o_MEM_ENa, bus.o_MEM_ENc} !== 2'b01) begin
      n_errors++; $display("FAIL rd_issue got gnt=%b ena_enc=%b exp gnt=0100 ena_enc=01",
                           bus.o_GNT, {bus.o_MEM_ENa, bus.o_MEM_ENc});
    end
    @(negedge clk); clear_inputs(); #1;
    n_checks++;
    if (bus.o_RVALID !== 4'b0100 || bus.o_RDATA !== 32'h1234_5678) begin
      n_errors++; $display("FAIL raw_resp got rv=%b data=%h exp rv=0100 data=12345678", bus.o_RVALID, bus.o_RDATA);
    end
  endtask

  task automatic test_lock_rmw();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 15'h0050, '0);
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0001) begin n_errors++; $display("FAIL lock_pre got=%b exp=0001", bus.o_GNT); end
    @(negedge clk);
    for (int k = 0; k < N; k++) set_req(k, 1'b0, k == 1, ADDR_W'(32'h60 + k), '0);
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0010 || bus.o_RVALID !== 4'b0001 || bus.o_RDATA !== init_word(32'h50)) begin
      n_errors++; $display("FAIL lock_enter got gnt=%b rv=%b data=%h exp gnt=0010 rv=0001 data=%h",
                           bus.o_GNT, bus.o_RVALID, bus.o_RDATA, init_word(32'h50));
    end
    @(negedge clk);
    bus.i_REQ[1] = 1'b0;
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0000 || bus.o_RVALID !== 4'b0010 || bus.o_RDATA !== init_word(32'h61)) begin
      n_errors++; $display("FAIL lock_hold got gnt=%b rv=%b data=%h exp gnt=0000 rv=0010 data=%h",
                           bus.o_GNT, bus.o_RVALID, bus.o_RDATA, init_word(32'h61));
    end
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 15'h0061, 32'hA5A5_0001);
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0010 || bus.o_MEM_ENa !== 1'b1) begin
      n_errors++; $display("FAIL lock_write got gnt=%b ena=%b exp gnt=0010 ena=1", bus.o_GNT, bus.o_MEM_ENa);
    end
    @(negedge clk);
    bus.i_REQ[1] = 1'b0;
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0100) begin n_errors++; $display("FAIL lock_release_next got=%b exp=0100", bus.o_GNT); end
  endtask

  task automatic test_lock_timeout();
    do_reset();
    @(negedge clk);
    set_req(3, 1'b0, 1'b1, 15'h0040, '0);
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b1000) begin n_errors++; $display("FAIL to_enter got=%b exp=1000", bus.o_GNT); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.i_REQ[3] = 1'b0;
        set_req(0, 1'b0, 1'b0, 15'h0041, '0);
      end
      #1;
      n_checks++;
      if (bus.o_GNT !== 4'b0000 || bus.o_LOCK_ERR !== 1'b0) begin
        n_errors++; $display("FAIL to_locked cycle=%0d got gnt=%b err=%b exp gnt=0000 err=0", c, bus.o_GNT, bus.o_LOCK_ERR);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus.o_LOCK_ERR !== 1'b1 || bus.o_GNT !== 4'b0001) begin
      n_errors++; $display("FAIL to_release got err=%b gnt=%b exp err=1 gnt=0001", bus.o_LOCK_ERR, bus.o_GNT);
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus.o_LOCK_ERR !== 1'b0) begin n_errors++; $display("FAIL to_pulse_width got err=%b exp=0", bus.o_LOCK_ERR); end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b0, ADDR_W'(32'h70 + k), '0);
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0100 || bus.o_RVALID !== 4'b0010) begin
      n_errors++; $display("FAIL ar_before got gnt=%b rv=%b exp gnt=0100 rv=0010", bus.o_GNT, bus.o_RVALID);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0000 || {bus.o_MEM_ENa, bus.o_MEM_ENc} !== 2'b00 || bus.o_RVALID !== 4'b0000) begin
      n_errors++; $display("FAIL ar_during got gnt=%b en=%b rv=%b exp gnt=0000 en=00 rv=0000",
                           bus.o_GNT, {bus.o_MEM_ENa, bus.o_MEM_ENc}, bus.o_RVALID);
    end
    @(negedge clk); #1;
    rst_n = 1'b1; #1;
    n_checks++;
    if (bus.o_GNT !== 4'b0001 || bus.o_RVALID !== 4'b0000) begin
      n_errors++; $display("FAIL ar_after got gnt=%b rv=%b exp gnt=0001 rv=0000", bus.o_GNT, bus.o_RVALID);
    end
  endtask

  task automatic test_random();
    int           w;
    logic [N-1:0] exp_g;
    logic [2:0]   exp_en;
    do_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_rv = '0; m_err = 0;
    mmem.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      clear_inputs();
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 99) < 60)
          set_req(k, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 25,
                  ADDR_W'(32'h300 + $urandom_range(0, 15)), $urandom);
      end
      #1;
      w = model_winner();
      exp_g = '0;
      if (w >= 0) exp_g[w] = 1'b1;
      exp_en = (w < 0) ? 3'b000 : (bus.i_WE[w] ? 3'b110 : 3'b001);
      n_checks++;
      if (bus.o_GNT !== exp_g) begin n_errors++; $display("FAIL rnd_gnt cycle=%0d got=%b exp=%b", c, bus.o_GNT, exp_g); end
      n_checks++;
      if ({bus.o_MEM_ENa, bus.o_MEM_WEa, bus.o_MEM_ENc} !== exp_en) begin
        n_errors++; $display("FAIL rnd_en cycle=%0d got=%b exp=%b", c, {bus.o_MEM_ENa, bus.o_MEM_WEa, bus.o_MEM_ENc}, exp_en);
      end
      if (exp_en == 3'b110) begin
        n_checks++;
        if (bus.o_MEM_ADDRa !== bus.i_ADDR[w*ADDR_W +: ADDR_W] || bus.o_MEM_WDATAa !== bus.i_WDATA[w*DATA_W +: DATA_W]) begin
          n_errors++; $display("FAIL rnd_wr_fields cycle=%0d got addr=%h data=%h exp addr=%h data=%h", c, bus.o_MEM_ADDRa,
                               bus.o_MEM_WDATAa, bus.i_ADDR[w*ADDR_W +: ADDR_W], bus.i_WDATA[w*DATA_W +: DATA_W]);
        end
      end else if (exp_en == 3'b001) begin
        n_checks++;
        if (bus.o_MEM_ADDRc !== bus.i_ADDR[w*ADDR_W +: ADDR_W]) begin
          n_errors++; $display("FAIL rnd_rd_addr cycle=%0d got=%h exp=%h", c, bus.o_MEM_ADDRc, bus.i_ADDR[w*ADDR_W +: ADDR_W]);
        end
      end
      n_checks++;
      if (bus.o_RVALID !== m_rv || bus.o_LOCK_ERR !== m_err) begin
        n_errors++; $display("FAIL rnd_rv_err cycle=%0d got rv=%b err=%b exp rv=%b err=%b", c, bus.o_RVALID,
                             bus.o_LOCK_ERR, m_rv, m_err);
      end
      if (m_rv != '0) begin
        n_checks++;
        if (bus.o_RDATA !== m_rv_data) begin
          n_errors++; $display("FAIL rnd_rdata cycle=%0d got=%h exp=%h", c, bus.o_RDATA, m_rv_data);
        end
      end
      model_step(w);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_lock_rmw();
    test_lock_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
